// File: rtl/tdm_demux4.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux4
// Purpose  : Four-slot TDM demultiplexer. Distributes a serial sample stream
//            into channels a..d. The channel order matches the 4:1 mux
//            select encoding ({s1,s2}: 00->a, 01->b, 10->c, 11->d). Complete
//            frames are published atomically, together with a one-cycle
//            frame_valid strobe.
// Options  : TDM_DEMUX_SYNC_CHECK_EN - when defined, a frame_sync that arrives
//            while LOCKED at a slot other than 0 realigns the frame and
//            pulses sync_err. When undefined, frame_sync is only used to
//            acquire lock in HUNT.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_demux4 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    input  logic         frame_sync,
    output logic [W-1:0] ch_a,
    output logic [W-1:0] ch_b,
    output logic [W-1:0] ch_c,
    output logic [W-1:0] ch_d,
    output logic         frame_valid,
    output logic [1:0]   slot,
    output logic         locked,
    output logic         sync_err
);

    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [1:0]   r_slot;
    logic [1:0]   w_slot_nxt;
    logic         w_we_a;
    logic         w_we_b;
    logic         w_we_c;
    logic         w_frame_done;
    logic         r_frame_valid;
    logic [W-1:0] r_stage_a;
    logic [W-1:0] r_stage_b;
    logic [W-1:0] r_stage_c;
    logic [W-1:0] r_ch_a;
    logic [W-1:0] r_ch_b;
    logic [W-1:0] r_ch_c;
    logic [W-1:0] r_ch_d;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
    logic         w_sync_hit;
    logic         r_sync_err;
`endif

    // State and slot registers; reset drops back to HUNT at slot 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_HUNT;
            r_slot  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_slot  <= w_slot_nxt;
        end
    end

    // Next-state, slot advance and staging/output write enables
    always_comb begin
        w_state_nxt  = r_state;
        w_slot_nxt   = r_slot;
        w_we_a       = 1'b0;
        w_we_b       = 1'b0;
        w_we_c       = 1'b0;
        w_frame_done = 1'b0;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
        w_sync_hit   = 1'b0;
`endif
        case (r_state)
            ST_HUNT: begin
                // Only a qualified sync marker starts a frame; the sync
                // sample itself is slot 0 of that frame.
                if (din_valid && frame_sync) begin
                    w_we_a      = 1'b1;
                    w_slot_nxt  = 2'd1;
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (din_valid) begin
`ifdef TDM_DEMUX_SYNC_CHECK_EN
                    // Misaligned sync: drop the partial frame and restart
                    // with this sample as slot 0.
                    if (frame_sync && (r_slot != 2'd0)) begin
                        w_sync_hit = 1'b1;
                        w_we_a     = 1'b1;
                        w_slot_nxt = 2'd1;
                    end else
`endif
                    begin
                        case (r_slot)
                            2'd0:    w_we_a       = 1'b1;
                            2'd1:    w_we_b       = 1'b1;
                            2'd2:    w_we_c       = 1'b1;
                            default: w_frame_done = 1'b1;
                        endcase
                        w_slot_nxt = r_slot + 2'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_HUNT;
            end
        endcase
    end

    // Staging registers for slots 0..2; their content is never visible
    // until a frame completes, so they carry no reset.
    always_ff @(posedge clk) begin
        if (w_we_a) r_stage_a <= din;
        if (w_we_b) r_stage_b <= din;
        if (w_we_c) r_stage_c <= din;
    end

    // Publish a completed frame: all four channels update on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch_a        <= '0;
            r_ch_b        <= '0;
            r_ch_c        <= '0;
            r_ch_d        <= '0;
            r_frame_valid <= 1'b0;
        end else begin
            r_frame_valid <= w_frame_done;
            if (w_frame_done) begin
                r_ch_a <= r_stage_a;
                r_ch_b <= r_stage_b;
                r_ch_c <= r_stage_c;
                r_ch_d <= din;
            end
        end
    end

`ifdef TDM_DEMUX_SYNC_CHECK_EN
    // One-cycle error pulse following a misaligned sync sample
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_err <= 1'b0;
        end else begin
            r_sync_err <= w_sync_hit;
        end
    end

    assign sync_err = r_sync_err;
`else
    assign sync_err = 1'b0;
`endif

    assign ch_a        = r_ch_a;
    assign ch_b        = r_ch_b;
    assign ch_c        = r_ch_c;
    assign ch_d        = r_ch_d;
    assign frame_valid = r_frame_valid;
    assign slot        = r_slot;
    assign locked      = (r_state == ST_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux4.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdm_demux4
// Purpose  : Directed self-checking bench for tdm_demux4 (W=8). Expected
//            values are hand-computed. Expectations for the misaligned-sync
//            case follow TDM_DEMUX_SYNC_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_demux4;

    localparam int C_W = 8;

    logic           clk;
    logic           rst;
    logic [C_W-1:0] din;
    logic           din_valid;
    logic           frame_sync;
    logic [C_W-1:0] ch_a;
    logic [C_W-1:0] ch_b;
    logic [C_W-1:0] ch_c;
    logic [C_W-1:0] ch_d;
    logic           frame_valid;
    logic [1:0]     slot;
    logic           locked;
    logic           sync_err;

    int n_tests;
    int n_fail;

    tdm_demux4 #(.W(C_W)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .ch_a        (ch_a),
        .ch_b        (ch_b),
        .ch_c        (ch_c),
        .ch_d        (ch_d),
        .frame_valid (frame_valid),
        .slot        (slot),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Apply one cycle of input; outputs are sampled 1ns after the edge
    task automatic drive(input logic v, input logic s, input logic [C_W-1:0] d);
        din_valid  = v;
        frame_sync = s;
        din        = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_ch(input string tag, input logic [C_W-1:0] a, input logic [C_W-1:0] b,
                            input logic [C_W-1:0] c, input logic [C_W-1:0] d);
        check_val({tag, "_a"}, 32'(ch_a), 32'(a));
        check_val({tag, "_b"}, 32'(ch_b), 32'(b));
        check_val({tag, "_c"}, 32'(ch_c), 32'(c));
        check_val({tag, "_d"}, 32'(ch_d), 32'(d));
    endtask

    // Gapped-valid pattern and the data carried on the valid cycles
    logic       gap_v [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] gap_d [7] = '{8'h00, 8'hEE, 8'hEE, 8'h01, 8'h00, 8'hEE, 8'h01};
    logic [1:0] gap_s [7] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0};

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b1;
        din        = '0;
        din_valid  = 1'b0;
        frame_sync = 1'b0;

        // Reset state
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        check_ch("rst", 8'h00, 8'h00, 8'h00, 8'h00);
        check_val("rst_fv", 32'(frame_valid), 32'd0);
        check_val("rst_slot", 32'(slot), 32'd0);
        check_val("rst_locked", 32'(locked), 32'd0);
        check_val("rst_serr", 32'(sync_err), 32'd0);

        // Samples before any sync are discarded
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 8'h01);
            check_val("hunt_fv", 32'(frame_valid), 32'd0);
        end
        check_val("hunt_locked", 32'(locked), 32'd0);
        check_val("hunt_slot", 32'(slot), 32'd0);
        check_ch("hunt", 8'h00, 8'h00, 8'h00, 8'h00);

        // First frame 1,0,1,1
        drive(1'b1, 1'b1, 8'h01);
        check_val("f1_locked", 32'(locked), 32'd1);
        check_val("f1_slot1", 32'(slot), 32'd1);
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h01);
        check_val("f1_slot3", 32'(slot), 32'd3);
        check_val("f1_fv_early", 32'(frame_valid), 32'd0);
        check_ch("f1_partial", 8'h00, 8'h00, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 8'h01);
        check_ch("f1", 8'h01, 8'h00, 8'h01, 8'h01);
        check_val("f1_fv", 32'(frame_valid), 32'd1);
        check_val("f1_slot0", 32'(slot), 32'd0);
        check_val("f1_locked2", 32'(locked), 32'd1);
        drive(1'b0, 1'b0, 8'h00);
        check_val("f1_fv_once", 32'(frame_valid), 32'd0);
        check_ch("f1_hold", 8'h01, 8'h00, 8'h01, 8'h01);

        // Gapped valid across one frame: 0,1,0,1 on valid cycles
        for (int i = 0; i < 7; i++) begin
            drive(gap_v[i], (i == 0), gap_d[i]);
            check_val($sformatf("gap_slot%0d", i), 32'(slot), 32'(gap_s[i]));
            check_val($sformatf("gap_fv%0d", i), 32'(frame_valid), (i == 6) ? 32'd1 : 32'd0);
        end
        check_ch("gap", 8'h00, 8'h01, 8'h00, 8'h01);

        // Misaligned frame_sync at slot 2
        drive(1'b1, 1'b1, 8'h10);
        drive(1'b1, 1'b0, 8'h11);
        check_val("mis_slot2", 32'(slot), 32'd2);
        drive(1'b1, 1'b1, 8'h12);
        check_val("mis_fv", 32'(frame_valid), 32'd0);
`ifdef TDM_DEMUX_SYNC_CHECK_EN
        check_val("mis_serr", 32'(sync_err), 32'd1);
        check_val("mis_slot", 32'(slot), 32'd1);
        drive(1'b1, 1'b0, 8'h13);
        check_val("mis_serr_once", 32'(sync_err), 32'd0);
        check_val("mis_fv2", 32'(frame_valid), 32'd0);
        drive(1'b1, 1'b0, 8'h14);
        drive(1'b1, 1'b0, 8'h15);
        check_val("mis_fv3", 32'(frame_valid), 32'd1);
        check_ch("mis", 8'h12, 8'h13, 8'h14, 8'h15);
`else
        check_val("mis_serr", 32'(sync_err), 32'd0);
        check_val("mis_slot", 32'(slot), 32'd3);
        drive(1'b1, 1'b0, 8'h13);
        check_val("mis_fv3", 32'(frame_valid), 32'd1);
        check_ch("mis", 8'h10, 8'h11, 8'h12, 8'h13);
`endif
        check_val("mis_slot0", 32'(slot), 32'd0);

        // Reset at slot 2 of the second frame
        drive(1'b1, 1'b0, 8'h21);
        drive(1'b1, 1'b0, 8'h22);
        drive(1'b1, 1'b0, 8'h23);
        drive(1'b1, 1'b0, 8'h24);
        check_ch("pre_rst", 8'h21, 8'h22, 8'h23, 8'h24);
        drive(1'b1, 1'b1, 8'h55);
        drive(1'b1, 1'b0, 8'h66);
        check_val("mid_slot2", 32'(slot), 32'd2);
        rst = 1'b1;
        drive(1'b1, 1'b1, 8'h77);
        rst = 1'b0;
        check_ch("mid_rst", 8'h00, 8'h00, 8'h00, 8'h00);
        check_val("mid_rst_locked", 32'(locked), 32'd0);
        check_val("mid_rst_slot", 32'(slot), 32'd0);
        check_val("mid_rst_fv", 32'(frame_valid), 32'd0);
        drive(1'b1, 1'b0, 8'h88);
        drive(1'b1, 1'b0, 8'h99);
        check_val("post_rst_locked", 32'(locked), 32'd0);

        // Back-to-back frames, W=8 data
        drive(1'b1, 1'b1, 8'hA5);
        drive(1'b1, 1'b0, 8'h3C);
        drive(1'b1, 1'b0, 8'hFF);
        check_ch("b2b_partial", 8'h00, 8'h00, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        check_val("b2b_fv1", 32'(frame_valid), 32'd1);
        check_ch("b2b1", 8'hA5, 8'h3C, 8'hFF, 8'h00);
        drive(1'b1, 1'b1, 8'h01);
        check_val("b2b_gap_fv", 32'(frame_valid), 32'd0);
        drive(1'b1, 1'b0, 8'h02);
        drive(1'b1, 1'b0, 8'h03);
        check_ch("b2b_hold", 8'hA5, 8'h3C, 8'hFF, 8'h00);
        check_val("b2b_fv_quiet", 32'(frame_valid), 32'd0);
        drive(1'b1, 1'b0, 8'h04);
        check_val("b2b_fv2", 32'(frame_valid), 32'd1);
        check_ch("b2b2", 8'h01, 8'h02, 8'h03, 8'h04);
        drive(1'b0, 1'b0, 8'h00);
        check_val("b2b_fv_end", 32'(frame_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
